// File: rtl/vga_timing_gen_pkg.sv
// Shared raster-timing constants and helpers for the VGA output path.
// Defaults describe 640x480 @ 60 Hz with a 25 MHz pixel rate.
package vga_timing_gen_pkg;

  localparam int unsigned CoordW = 10;
  localparam int unsigned MaxTot = 1 << CoordW;

  localparam int unsigned DefHVis  = 640;
  localparam int unsigned DefHFp   = 16;
  localparam int unsigned DefHSync = 96;
  localparam int unsigned DefHBp   = 48;
  localparam int unsigned DefVVis  = 480;
  localparam int unsigned DefVFp   = 10;
  localparam int unsigned DefVSync = 2;
  localparam int unsigned DefVBp   = 33;

  typedef logic [CoordW-1:0] coord_t;

  function automatic int unsigned span_total(input int unsigned vis, input int unsigned fp,
                                             input int unsigned sync, input int unsigned bp);
    return vis + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Raster timing generator: h/v counters plus a registered decode of coordinates,
// syncs, display enable and line/frame strobes, all advancing on pix_ce.
module vga_timing_gen
  import vga_timing_gen_pkg::*;
#(
  parameter int unsigned H_VIS    = DefHVis,
  parameter int unsigned H_FP     = DefHFp,
  parameter int unsigned H_SYNC   = DefHSync,
  parameter int unsigned H_BP     = DefHBp,
  parameter int unsigned V_VIS    = DefVVis,
  parameter int unsigned V_FP     = DefVFp,
  parameter int unsigned V_SYNC   = DefVSync,
  parameter int unsigned V_BP     = DefVBp,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pix_ce,
  output logic [CoordW-1:0] pix_x,
  output logic [CoordW-1:0] pix_y,
  output logic              hsync,
  output logic              vsync,
  output logic              de,
  output logic              line_start,
  output logic              frame_start,
  output logic [7:0]        frame_count
);

  localparam int unsigned HTot = span_total(H_VIS, H_FP, H_SYNC, H_BP);
  localparam int unsigned VTot = span_total(V_VIS, V_FP, V_SYNC, V_BP);

  localparam coord_t HLast      = coord_t'(HTot - 1);
  localparam coord_t VLast      = coord_t'(VTot - 1);
  localparam coord_t HVis       = coord_t'(H_VIS);
  localparam coord_t VVis       = coord_t'(V_VIS);
  localparam coord_t HSyncStart = coord_t'(H_VIS + H_FP);
  localparam coord_t HSyncEnd   = coord_t'(H_VIS + H_FP + H_SYNC);
  localparam coord_t VSyncStart = coord_t'(V_VIS + V_FP);
  localparam coord_t VSyncEnd   = coord_t'(V_VIS + V_FP + V_SYNC);

  if (HTot > MaxTot || VTot > MaxTot) begin : g_bad_timing
    $error("vga_timing_gen: H_TOT or V_TOT does not fit the coordinate width");
  end

  coord_t h_cnt;
  coord_t v_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      frame_count <= '0;
    end else if (pix_ce) begin
      if (h_cnt == HLast) begin
        h_cnt <= '0;
        if (v_cnt == VLast) begin
          v_cnt       <= '0;
          frame_count <= frame_count + 8'd1;
        end else begin
          v_cnt <= v_cnt + 1'b1;
        end
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end
  end

  // Decode uses the pre-increment counts so every output describes the same pixel.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pix_x       <= '0;
      pix_y       <= '0;
      de          <= 1'b0;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (pix_ce) begin
      pix_x       <= h_cnt;
      pix_y       <= v_cnt;
      de          <= (h_cnt < HVis) && (v_cnt < VVis);
      hsync       <= (h_cnt >= HSyncStart && h_cnt < HSyncEnd) ? SYNC_POL : ~SYNC_POL;
      vsync       <= (v_cnt >= VSyncStart && v_cnt < VSyncEnd) ? SYNC_POL : ~SYNC_POL;
      line_start  <= (h_cnt == '0);
      frame_start <= (h_cnt == '0) && (v_cnt == '0);
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen on a shrunken raster (15 x 8) so whole
// frames and a 256-frame counter wrap stay short.
module tb_vga_timing_gen;

  localparam int unsigned HV = 8, HF = 2, HS = 3, HB = 2;
  localparam int unsigned VV = 4, VF = 1, VS = 2, VB = 1;
  localparam int unsigned HT = HV + HF + HS + HB;  // 15
  localparam int unsigned VT = VV + VF + VS + VB;  // 8

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       de;
    logic       ls;
    logic       fs;
    logic [7:0] fc;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pix_ce = 1'b0;
  logic [9:0] pix_x, pix_y;
  logic       hsync, vsync, de, line_start, frame_start;
  logic [7:0] frame_count;

  vga_timing_gen #(
    .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(1'b0)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pix_ce     (pix_ce),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .hsync      (hsync),
    .vsync      (vsync),
    .de         (de),
    .line_start (line_start),
    .frame_start(frame_start),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  int   n_vec = 0;
  int   n_err = 0;
  obs_t exp_q[$];

  // Reference raster state
  int   mh = 0, mv = 0, mfc = 0;
  obs_t mexp;

  // Measurements taken by the stimulus side
  int cyc_n = 0, hs_lo = 0, vs_lo = 0, ls_n = 0, fs_n = 0, last_fs = 0, fs_period = 0;

  function automatic obs_t dut_obs();
    return '{x: pix_x, y: pix_y, hs: hsync, vs: vsync, de: de,
             ls: line_start, fs: frame_start, fc: frame_count};
  endfunction

  // Monitor: one expected entry per clock, compared just after the edge.
  always @(posedge clk) begin
    obs_t e, a;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = dut_obs();
      n_vec++;
      if (a !== e) begin
        n_err++;
        $display("FAIL scoreboard t=%0t got x=%0d y=%0d hs=%b vs=%b de=%b ls=%b fs=%b fc=%0d want x=%0d y=%0d hs=%b vs=%b de=%b ls=%b fs=%b fc=%0d",
                 $time, a.x, a.y, a.hs, a.vs, a.de, a.ls, a.fs, a.fc,
                 e.x, e.y, e.hs, e.vs, e.de, e.ls, e.fs, e.fc);
      end
    end
  end

  task automatic dcheck(input string name, input int act, input int want);
    n_vec++;
    if (act != want) begin
      n_err++;
      $display("FAIL %s got %0d want %0d", name, act, want);
    end
  endtask

  task automatic cyc(input bit r, input bit ce);
    @(negedge clk);
    rst_n  = r;
    pix_ce = ce;
    if (!r) begin
      mh = 0; mv = 0; mfc = 0;
      mexp = '{x: 0, y: 0, hs: 1'b1, vs: 1'b1, de: 1'b0, ls: 1'b0, fs: 1'b0, fc: 8'd0};
    end else if (ce) begin
      mexp.x  = 10'(mh);
      mexp.y  = 10'(mv);
      mexp.de = (mh < HV) && (mv < VV);
      mexp.hs = !(mh >= HV + HF && mh < HV + HF + HS);
      mexp.vs = !(mv >= VV + VF && mv < VV + VF + VS);
      mexp.ls = (mh == 0);
      mexp.fs = (mh == 0) && (mv == 0);
      mh++;
      if (mh == HT) begin
        mh = 0;
        mv++;
        if (mv == VT) begin
          mv = 0;
          mfc = (mfc + 1) % 256;
        end
      end
      mexp.fc = 8'(mfc);
    end else begin
      mexp.ls = 1'b0;
      mexp.fs = 1'b0;
    end
    exp_q.push_back(mexp);
    @(posedge clk);
    #2;
    cyc_n++;
    if (!hsync) hs_lo++;
    if (!vsync) vs_lo++;
    if (line_start) ls_n++;
    if (frame_start) begin
      fs_n++;
      fs_period = cyc_n - last_fs;
      last_fs = cyc_n;
    end
  endtask

  task automatic clear_meas();
    hs_lo = 0; vs_lo = 0; ls_n = 0; fs_n = 0;
  endtask

  initial begin
    mexp = '0;
    // Reset and first pixel
    repeat (5) cyc(1'b0, 1'b1);
    dcheck("reset_hsync", int'(hsync), 1);
    dcheck("reset_vsync", int'(vsync), 1);
    dcheck("reset_de", int'(de), 0);
    dcheck("reset_fc", int'(frame_count), 0);
    clear_meas();
    cyc(1'b1, 1'b1);
    dcheck("first_x", int'(pix_x), 0);
    dcheck("first_y", int'(pix_y), 0);
    dcheck("first_de", int'(de), 1);
    dcheck("first_fs", int'(frame_start), 1);
    dcheck("first_ls", int'(line_start), 1);
    cyc(1'b1, 1'b1);
    dcheck("second_x", int'(pix_x), 1);
    dcheck("second_fs", int'(frame_start), 0);

    // Rest of the first frame: ends presenting (7,14)
    repeat (118) cyc(1'b1, 1'b1);
    dcheck("last_x", int'(pix_x), 14);
    dcheck("last_y", int'(pix_y), 7);
    dcheck("fc_after_frame", int'(frame_count), 1);
    dcheck("hsync_low_clks", hs_lo, 8 * 3);
    dcheck("vsync_low_clks", vs_lo, 2 * 15);
    dcheck("lines_per_frame", ls_n, 8);
    cyc(1'b1, 1'b1);
    dcheck("wrap_fs", int'(frame_start), 1);
    dcheck("wrap_x", int'(pix_x), 0);
    dcheck("frame_period", fs_period, 120);

    // Clock enable at half rate
    clear_meas();
    for (int i = 0; i < 240; i++) cyc(1'b1, i[0]);
    dcheck("ce_frame_period", fs_period, 240);
    dcheck("ce_line_strobes", ls_n, 8);
    dcheck("ce_frame_strobes", fs_n, 1);
    dcheck("ce_fc", int'(frame_count), 2);

    // Mid-frame reset at pixel (5,2)
    repeat (35) cyc(1'b1, 1'b1);
    dcheck("pre_rst_x", int'(pix_x), 5);
    dcheck("pre_rst_y", int'(pix_y), 2);
    cyc(1'b0, 1'b1);
    dcheck("mid_rst_fc", int'(frame_count), 0);
    cyc(1'b1, 1'b1);
    dcheck("post_rst_fs", int'(frame_start), 1);
    dcheck("post_rst_y", int'(pix_y), 0);

    // 256 frames: frame_count passes 255 -> 0
    repeat (119 + 254 * 120) cyc(1'b1, 1'b1);
    dcheck("fc_255", int'(frame_count), 255);
    repeat (120) cyc(1'b1, 1'b1);
    dcheck("fc_wrap", int'(frame_count), 0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #3;
    dcheck("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench timed out");
  end

endmodule
